// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: opcode valid/ready handshake between fetch
// and the multi-cycle control unit.
interface multicycle_control_fsm_if #(
  parameter int OPCODE_W = 7
);
  logic [OPCODE_W-1:0] Opcode;
  logic                InstrValid;
  logic                Ready;

  modport master (
    output Opcode,
    output InstrValid,
    input  Ready
  );

  modport slave (
    input  Opcode,
    input  InstrValid,
    output Ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: IDLE/DECODE/EXEC/MEM/WB sequencer for RV32 opcodes.
// Optional retired-instruction counter built when MCF_PERF_CNT_EN is defined.
module multicycle_control_fsm #(
  parameter int OPCODE_W    = 7,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5,
  parameter int PERF_W      = 32
) (
  input  logic                     CLK,
  input  logic                     Reset_n,
  multicycle_control_fsm_if.slave  instr,
  input  logic                     MemAck,
  output logic                     ALUSrc,
  output logic                     MemtoReg,
  output logic                     RegDst,
  output logic [1:0]               ALUOp,
  output logic                     RegWrite,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic                     Branch,
  output logic                     Jump,
  output logic                     Done,
  output logic                     IllegalOp,
  output logic                     MemErr,
  output logic [PERF_W-1:0]        InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    K_ALU_R,
    K_ALU_I,
    K_LOAD,
    K_STORE,
    K_BRANCH,
    K_LUI,
    K_JAL,
    K_ILL
  } kind_t;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_dst;
    logic [1:0] alu_op;
  } dec_t;

  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(7'h33);
  localparam logic [OPCODE_W-1:0] OP_I   = OPCODE_W'(7'h13);
  localparam logic [OPCODE_W-1:0] OP_LD  = OPCODE_W'(7'h03);
  localparam logic [OPCODE_W-1:0] OP_ST  = OPCODE_W'(7'h23);
  localparam logic [OPCODE_W-1:0] OP_BR  = OPCODE_W'(7'h63);
  localparam logic [OPCODE_W-1:0] OP_LUI = OPCODE_W'(7'h37);
  localparam logic [OPCODE_W-1:0] OP_JAL = OPCODE_W'(7'h6F);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state;
  kind_t            kind_q;
  logic             ready_q;
  logic [TMO_W-1:0] tmo_q;

  // Full-width compare: any set bit above [6:0] misses every entry.
  function automatic kind_t classify(
    input logic [OPCODE_W-1:0] op
  );
    kind_t k;
    k = K_ILL;
    unique case (1'b1)
      (op == OP_R):   k = K_ALU_R;
      (op == OP_I):   k = K_ALU_I;
      (op == OP_LD):  k = K_LOAD;
      (op == OP_ST):  k = K_STORE;
      (op == OP_BR):  k = K_BRANCH;
      (op == OP_LUI): k = K_LUI;
      (op == OP_JAL): k = K_JAL;
      default:        k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic dec_t decode(input kind_t k);
    dec_t d;
    d = '0;
    unique case (k)
      K_ALU_R: begin
        d.reg_dst = 1'b1;
        d.alu_op  = 2'b10;
      end
      K_ALU_I: begin
        d.alu_src = 1'b1;
        d.alu_op  = 2'b10;
      end
      K_LOAD: begin
        d.alu_src    = 1'b1;
        d.mem_to_reg = 1'b1;
      end
      K_STORE: begin
        d.alu_src = 1'b1;
      end
      K_BRANCH: begin
        d.alu_op = 2'b01;
      end
      K_LUI: begin
        d.alu_src = 1'b1;
        d.alu_op  = 2'b11;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  assign instr.Ready = ready_q;

  // Sequencer: each output is loaded on the edge that enters the cycle
  // in which it must be visible; pulses fall back to 0 every edge.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      kind_q    <= K_ILL;
      ready_q   <= 1'b0;
      tmo_q     <= '0;
      ALUSrc    <= 1'b0;
      MemtoReg  <= 1'b0;
      RegDst    <= 1'b0;
      ALUOp     <= 2'b00;
      RegWrite  <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Branch    <= 1'b0;
      Jump      <= 1'b0;
      Done      <= 1'b0;
      IllegalOp <= 1'b0;
      MemErr    <= 1'b0;
    end else begin
      RegWrite  <= 1'b0;
      Branch    <= 1'b0;
      Jump      <= 1'b0;
      Done      <= 1'b0;
      IllegalOp <= 1'b0;
      MemErr    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ready_q && instr.InstrValid) begin
            kind_q    <= classify(instr.Opcode);
            IllegalOp <= (classify(instr.Opcode) == K_ILL);
            ready_q   <= 1'b0;
            state     <= S_DECODE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_DECODE: begin
          if (kind_q == K_ILL) begin
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end else begin
            {ALUSrc, MemtoReg, RegDst, ALUOp} <= decode(kind_q);
            Branch <= (kind_q == K_BRANCH);
            Done   <= (kind_q == K_BRANCH);
            Jump   <= (kind_q == K_JAL);
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (kind_q)
            K_BRANCH: begin
              {ALUSrc, MemtoReg, RegDst, ALUOp} <= '0;
              ready_q <= 1'b1;
              state   <= S_IDLE;
            end
            K_LOAD: begin
              MemRead <= 1'b1;
              tmo_q   <= '0;
              state   <= S_MEM;
            end
            K_STORE: begin
              MemWrite <= 1'b1;
              tmo_q    <= '0;
              state    <= S_MEM;
            end
            default: begin
              RegWrite <= 1'b1;
              Done     <= 1'b1;
              state    <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (MemAck) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            Done     <= 1'b1;
            if (kind_q == K_LOAD) begin
              RegWrite <= 1'b1;
              state    <= S_WB;
            end else begin
              {ALUSrc, MemtoReg, RegDst, ALUOp} <= '0;
              state <= S_IDLE;
            end
          end else if (tmo_q == TMO_LAST) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            MemErr   <= 1'b1;
            {ALUSrc, MemtoReg, RegDst, ALUOp} <= '0;
            state <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_WB: begin
          {ALUSrc, MemtoReg, RegDst, ALUOp} <= '0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MCF_PERF_CNT_EN
  logic [PERF_W-1:0] count_q;

  // Retired-instruction counter; bumps the cycle after each Done pulse.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else if (Done) begin
      count_q <= count_q + PERF_W'(1);
    end
  end

  assign InstrCount = count_q;
`else
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: cycle schedule built from the instruction
// timing rules, compared against the DUT on every cycle.
module tb_multicycle_control_fsm;

  localparam int OW = 8;
`ifdef MCF_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ack = 1'b0;
  logic        alu_src, mem_to_reg, reg_dst;
  logic [1:0]  alu_op;
  logic        reg_write, mem_read, mem_write;
  logic        branch, jump, done, illegal_op, mem_err;
  logic [31:0] instr_count;

  multicycle_control_fsm_if #(.OPCODE_W(OW)) ifc ();

  multicycle_control_fsm #(
    .OPCODE_W    (OW),
    .MEM_TIMEOUT (16),
    .TMO_W       (5),
    .PERF_W      (32)
  ) dut (
    .CLK        (clk),
    .Reset_n    (rst_n),
    .instr      (ifc),
    .MemAck     (mem_ack),
    .ALUSrc     (alu_src),
    .MemtoReg   (mem_to_reg),
    .RegDst     (reg_dst),
    .ALUOp      (alu_op),
    .RegWrite   (reg_write),
    .MemRead    (mem_read),
    .MemWrite   (mem_write),
    .Branch     (branch),
    .Jump       (jump),
    .Done       (done),
    .IllegalOp  (illegal_op),
    .MemErr     (mem_err),
    .InstrCount (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        alusrc;
    logic        m2r;
    logic        regdst;
    logic [1:0]  aluop;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic        dn;
    logic        ill;
    logic        merr;
    logic [31:0] cnt;
  } ov_t;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] op;
    logic       ack;
    logic       acc;
    ov_t        e;
  } ent_t;

  ent_t        sched[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cnt_m = '0;
  int          last_lat = -1;

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic put(input logic rn, input logic v, input logic [7:0] op,
                     input logic ack, input ov_t e, input logic acc);
    ent_t t;
    e.cnt   = cnt_m;
    t.rst_n = rn;
    t.valid = v;
    t.op    = op;
    t.ack   = ack;
    t.acc   = acc;
    t.e     = e;
    sched.push_back(t);
    if (PERF == 1 && e.dn) cnt_m = cnt_m + 32'd1;
  endtask

  function automatic ov_t dec(input logic [7:0] op);
    ov_t d;
    d = '0;
    case (op)
      8'h33: begin d.regdst = 1'b1; d.aluop = 2'b10; end
      8'h13: begin d.alusrc = 1'b1; d.aluop = 2'b10; end
      8'h03: begin d.alusrc = 1'b1; d.m2r = 1'b1; end
      8'h23: d.alusrc = 1'b1;
      8'h63: d.aluop = 2'b01;
      8'h37: begin d.alusrc = 1'b1; d.aluop = 2'b11; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic bit legal(input logic [7:0] op);
    return op inside {8'h33, 8'h13, 8'h03, 8'h23, 8'h63, 8'h37, 8'h6F};
  endfunction

  task automatic add_reset();
    ov_t z;
    z = '0;
    cnt_m = '0;
    put(1'b0, 1'b0, 8'h00, 1'b0, z, 1'b0);
    put(1'b1, 1'b0, 8'h00, 1'b0, z, 1'b0);
  endtask

  // ack_at: MEM cycle (1..16) carrying MemAck, 0 = never.
  // trunc: keep only that many post-accept cycles (0 = all).
  task automatic add_instr(input logic [7:0] op, input int ack_at,
                           input int gap, input int trunc);
    ov_t eq[$];
    int  aq[$];
    ov_t z, d, e;
    int  n, lim;
    z = '0;
    for (int i = 0; i < gap; i++) begin
      e = z; e.rdy = 1'b1;
      put(1'b1, 1'b0, 8'($urandom), 1'($urandom), e, 1'b0);
    end
    e = z; e.rdy = 1'b1;
    put(1'b1, 1'b1, op, 1'($urandom), e, 1'b1);
    d = dec(op);
    if (!legal(op)) begin
      e = z; e.ill = 1'b1;
      eq.push_back(e); aq.push_back(2);
    end else begin
      eq.push_back(z); aq.push_back(2);
      e = d;
      if (op == 8'h63) begin e.br = 1'b1; e.dn = 1'b1; end
      if (op == 8'h6F) e.jp = 1'b1;
      eq.push_back(e); aq.push_back(2);
      if (op == 8'h03 || op == 8'h23) begin
        n = (ack_at > 0) ? ack_at : 16;
        for (int i = 1; i <= n; i++) begin
          e = d;
          if (op == 8'h03) e.mr = 1'b1;
          else e.mw = 1'b1;
          eq.push_back(e);
          aq.push_back((i == ack_at) ? 1 : 0);
        end
        if (ack_at > 0 && op == 8'h03) begin
          e = d; e.rw = 1'b1; e.dn = 1'b1;
        end else if (ack_at > 0) begin
          e = z; e.dn = 1'b1;
        end else begin
          e = z; e.merr = 1'b1;
        end
        eq.push_back(e); aq.push_back(2);
      end else if (op != 8'h63) begin
        e = d; e.rw = 1'b1; e.dn = 1'b1;
        eq.push_back(e); aq.push_back(2);
      end
    end
    lim = (trunc > 0 && trunc < eq.size()) ? trunc : eq.size();
    for (int i = 0; i < lim; i++) begin
      put(1'b1, 1'($urandom), 8'($urandom),
          (aq[i] == 2) ? 1'($urandom) : 1'(aq[i]), eq[i], 1'b0);
    end
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (sched.size() > 0 && g < 20000) begin
      @(posedge clk);
      g++;
    end
    if (sched.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_%s: %0d cycles left, want 0", tag, sched.size());
      sched.delete();
    end
    @(negedge clk);
    #2;
  endtask

  // Compare process: drive one scheduled cycle, check outputs 1ns later.
  initial begin
    ent_t t;
    ov_t  act;
    int   cyc, acc_cyc;
    cyc = 0;
    acc_cyc = 0;
    ifc.InstrValid = 1'b0;
    ifc.Opcode = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sched.size() > 0) begin
        t = sched.pop_front();
        rst_n = t.rst_n;
        ifc.InstrValid = t.valid;
        ifc.Opcode = t.op;
        mem_ack = t.ack;
        #1;
        act = {ifc.Ready, alu_src, mem_to_reg, reg_dst, alu_op, reg_write,
               mem_read, mem_write, branch, jump, done, illegal_op,
               mem_err, instr_count};
        checks++;
        if (act !== t.e) begin
          errors++;
          $display("FAIL cycle %0d: got %h want %h", cyc, act, t.e);
        end
        if (t.acc) acc_cyc = cyc;
        if (done === 1'b1) last_lat = cyc - acc_cyc;
      end else begin
        rst_n = 1'b1;
        ifc.InstrValid = 1'b0;
        mem_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [10];
    logic [7:0] op;
    int         ack_at;
    ops = '{8'h33, 8'h13, 8'h03, 8'h23, 8'h63, 8'h37, 8'h6F,
            8'h7F, 8'hFF, 8'hB3};

    add_reset();
    add_instr(8'h33, 0, 1, 0);
    drain("r");
    chk("lat_r", last_lat, 3);
    add_instr(8'h63, 0, 0, 0);
    drain("br");
    chk("lat_branch", last_lat, 2);
    add_instr(8'h03, 1, 2, 0);
    drain("ld1");
    chk("lat_load_ack1", last_lat, 4);
    add_instr(8'h03, 3, 0, 0);
    drain("ld3");
    chk("lat_load_ack3", last_lat, 6);
    add_instr(8'h23, 0, 1, 0);
    drain("st_tmo");
    chk("cnt_after_tmo", instr_count, 4 * PERF);
    chk("rdy_after_tmo", ifc.Ready, 1);
    add_instr(8'h23, 16, 0, 0);
    drain("st16");
    chk("lat_store_ack16", last_lat, 19);
    add_instr(8'h7F, 0, 0, 0);
    add_instr(8'hFF, 0, 0, 0);
    drain("ill");
    chk("cnt_after_ill", instr_count, 5 * PERF);

    add_reset();
    add_instr(8'h63, 0, 0, 0);
    add_instr(8'h6F, 0, 0, 0);
    add_instr(8'h37, 0, 0, 0);
    drain("seq");
    chk("lat_lui", last_lat, 3);
    chk("cnt_seq", instr_count, 3 * PERF);

    add_instr(8'h03, 0, 0, 5);
    add_reset();
    drain("rst_mem");
    chk("cnt_after_rst", instr_count, 0);
    chk("rdy_after_rst", ifc.Ready, 1);
    chk("done_after_rst", done, 0);

    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 9)];
      ack_at = $urandom_range(0, 16);
      if ($urandom_range(0, 19) == 0) begin
        add_instr(op, ack_at, $urandom_range(0, 3), $urandom_range(1, 4));
        add_reset();
      end else begin
        add_instr(op, ack_at, $urandom_range(0, 3), 0);
      end
    end
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
